// File: rtl/core_test_pkg.sv
// rtl/core_test_pkg.sv - shared state and status encodings for the test result monitor
package core_test_pkg;

    typedef enum logic [1:0] {
        MON_RUN     = 2'd0,
        MON_PASS    = 2'd1,
        MON_FAIL    = 2'd2,
        MON_TIMEOUT = 2'd3
    } monitor_state_t;

    localparam logic [1:0] STATUS_RUN     = 2'd0;
    localparam logic [1:0] STATUS_PASS    = 2'd1;
    localparam logic [1:0] STATUS_FAIL    = 2'd2;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

    function automatic logic is_terminal(input monitor_state_t s);
        return s != MON_RUN;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that holds at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/test_result_monitor.sv
// rtl/test_result_monitor.sv - watches core stores for a result write and flags pass/fail/timeout
module test_result_monitor
    import core_test_pkg::*;
#(
    parameter int                   BIT_COUNT      = 32,
    parameter logic [BIT_COUNT-1:0] RESULT_ADDR    = 'hC,
    parameter logic [BIT_COUNT-1:0] EXPECTED_VALUE = 'h0F,
    parameter int                   TIMEOUT_CYCLES = 10000,
    parameter int                   STALL_CYCLES   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_COUNT-1:0] InstrAdr,
    input  logic                 MemEn,
    input  logic                 MemWrite,
    input  logic [BIT_COUNT-1:0] MemAdr,
    input  logic [BIT_COUNT-1:0] MemWriteData,
    output logic                 done,
    output logic                 pass,
    output logic [1:0]           status,
    output logic [BIT_COUNT-1:0] result,
    output logic [31:0]          cycle_count,
    output logic [31:0]          store_count
);

    monitor_state_t       state_q, state_d;
    logic [BIT_COUNT-1:0] result_q, result_d;
    logic [BIT_COUNT-1:0] prev_adr_q;
    logic                 done_q, pass_q;
    logic [31:0]          cycle_cnt, store_cnt, stall_cnt;

    logic run, any_store, result_store, adr_same, timeout_hit, stall_hit;

    assign run          = !is_terminal(state_q);
    assign any_store    = MemEn && MemWrite;
    assign result_store = any_store && (MemAdr == RESULT_ADDR);
    assign adr_same     = (InstrAdr == prev_adr_q);
    assign timeout_hit  = (cycle_cnt == 32'(TIMEOUT_CYCLES - 1));
    // Trips on the edge where the run of unchanged fetch addresses would reach STALL_CYCLES.
    assign stall_hit    = adr_same && (stall_cnt == 32'(STALL_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        if (run) begin
            if (result_store) begin
                state_d  = (MemWriteData == EXPECTED_VALUE) ? MON_PASS : MON_FAIL;
                result_d = MemWriteData;
            end else if (timeout_hit || stall_hit) begin
                state_d = MON_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MON_RUN;
            result_q   <= '0;
            prev_adr_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= is_terminal(state_d);
            pass_q   <= (state_d == MON_PASS);
            if (run) begin
                prev_adr_q <= InstrAdr;
            end
        end
    end

    sat_counter #(.WIDTH(32)) u_cycle_cnt (
        .clk_i   (clk),
        .clr_i   (reset),
        .inc_i   (run),
        .count_o (cycle_cnt)
    );

    sat_counter #(.WIDTH(32)) u_store_cnt (
        .clk_i   (clk),
        .clr_i   (reset),
        .inc_i   (run && any_store),
        .count_o (store_cnt)
    );

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk_i   (clk),
        .clr_i   (reset || (run && !adr_same)),
        .inc_i   (run && adr_same),
        .count_o (stall_cnt)
    );

    assign done        = done_q;
    assign pass        = pass_q;
    assign status      = state_q;
    assign result      = result_q;
    assign cycle_count = cycle_cnt;
    assign store_count = store_cnt;

endmodule

// File: doc/test_result_monitor.md
TEST_RESULT_MONITOR -- requirements
Module: test_result_monitor

Interface
REQ-001 SHALL have parameter BIT_COUNT, 32, datapath width of all address and data ports.
REQ-002 SHALL have parameter RESULT_ADDR, 32'hC, data-memory address that carries the program result.
REQ-003 SHALL have parameter EXPECTED_VALUE, 32'h0F, value required for pass.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 10000, RUN cycles allowed before timeout.
REQ-005 SHALL have parameter STALL_CYCLES, 64, consecutive cycles with unchanged InstrAdr treated as hung.
REQ-006 SHALL have one clock and synchronous active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous, active-high.
REQ-007 SHALL have ports: InstrAdr  input  BIT_COUNT  core fetch address; MemEn  input  1  data-memory access; MemWrite  input  1  access is a store; MemAdr  input  BIT_COUNT  store address; MemWriteData  input  BIT_COUNT  store data.
REQ-008 SHALL have outputs: done  output  1  terminal state reached; pass  output  1  result matched; status  output  2  state encoding; result  output  BIT_COUNT  captured result data; cycle_count  output  32  RUN cycles elapsed; store_count  output  32  stores observed.

Function
REQ-009 SHALL implement FSM states RUN=2'd0, PASS=2'd1, FAIL=2'd2, TIMEOUT=2'd3, driven on status.
REQ-010 SHALL define a result store as MemEn && MemWrite && MemAdr == RESULT_ADDR, sampled on rising clk.
REQ-011 In RUN, a result store with MemWriteData == EXPECTED_VALUE SHALL transition to PASS; any other data SHALL transition to FAIL.
REQ-012 On a result store, result SHALL capture MemWriteData in the same edge as the state transition.
REQ-013 done SHALL assert, and pass SHALL equal (status == PASS), one cycle after the qualifying store (registered outputs, latency 1).
REQ-014 PASS, FAIL, TIMEOUT SHALL be sticky; only reset leaves them; inputs ignored and counters frozen.
REQ-015 cycle_count SHALL increment once per RUN cycle, saturating at 32'hFFFF_FFFF.
REQ-016 store_count SHALL increment on every MemEn && MemWrite in RUN, including the result store, saturating.
REQ-017 When cycle_count == TIMEOUT_CYCLES-1 in RUN with no result store that cycle, SHALL transition to TIMEOUT.
REQ-018 Stall counter SHALL increment when InstrAdr equals its previous-cycle value, clear otherwise; reaching STALL_CYCLES SHALL transition to TIMEOUT.
REQ-019 Priority on the same edge: result store > timeout > stall.
REQ-020 Stores to any other address SHALL only affect store_count.
REQ-021 MemWrite without MemEn SHALL be ignored.

Reset
REQ-022 reset SHALL set status=RUN, done=0, pass=0, result=0, cycle_count=0, store_count=0, stall counter=0, previous InstrAdr=0.
REQ-023 reset asserted mid-run or in a terminal state SHALL take priority over all events on that edge; counting restarts from 0 the cycle after deassertion.

Structure
REQ-024 Shared package core_test_pkg SHALL hold monitor_state_t enum and status encodings for reuse by benches.
REQ-025 One sub-module sat_counter (parameterised width, inc, clr) SHALL implement cycle, store and stall counters.
REQ-026 Block SHALL be synthesizable, no $display/$stop; benches use done/pass.

Verification
REQ-027 Store 32'h0F to 32'hC at cycle 20 -> cycle 21 done=1, pass=1, status=1, result=32'h0F, cycle_count frozen at 21.
REQ-028 Store 32'h0E to 32'hC -> next cycle done=1, pass=0, status=2, result=32'h0E.
REQ-029 TIMEOUT_CYCLES=50, no result store, InstrAdr incrementing by 4 -> status=3 after 50 RUN cycles, cycle_count=50.
REQ-030 InstrAdr held at 32'h40 for 64 cycles -> status=3; changing it at cycle 63 -> remains RUN.
REQ-031 Stores to 32'h8 and 32'h10, then MemWrite=1 with MemEn=0 at 32'hC -> status=0, store_count=2.
REQ-032 Reach PASS, then reset one cycle -> all outputs zero, status=0; subsequent 32'h0F store to 32'hC passes again.
